bc_display_scan: RTL and testbench



---
 rtl/bc_pkg.sv | 38 +++
 rtl/bc_seg_decode.sv | 47 ++++
 rtl/bc_display_scan.sv | 174 +++++++++++++++++
 tb/tb_bc_display_scan.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// -----------------------------------------------------------------------------
// bc_pkg
// Shared definitions for the display path. The game FSM builds its frames from
// the same character codes, so the codes and their segment patterns live here.
//
// Contents:
//   CODE_W / SEG_W     widths of a character code and of a segment pattern
//   char_t / seg_t     convenience types for those widths
//   CH_*               character codes for the non-hex glyphs
//   SEG_*              active-low {g,f,e,d,c,b,a} patterns for those glyphs
// -----------------------------------------------------------------------------
package bc_pkg;

  localparam int CODE_W = 5;
  localparam int SEG_W  = 7;

  typedef logic [CODE_W-1:0] char_t;
  typedef logic [SEG_W-1:0]  seg_t;

  // Codes 0-15 are the hex digits themselves; 23-31 are unused and show blank.
  localparam char_t CH_BLANK = 5'd16;
  localparam char_t CH_DASH  = 5'd17;
  localparam char_t CH_P     = 5'd18;
  localparam char_t CH_L     = 5'd19;
  localparam char_t CH_U     = 5'd20;
  localparam char_t CH_N     = 5'd21;
  localparam char_t CH_R     = 5'd22;

  // Segment patterns are active-low: a 0 lights the segment.
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_P     = 7'b0001100;
  localparam seg_t SEG_L     = 7'b1000111;
  localparam seg_t SEG_U     = 7'b1000001;
  localparam seg_t SEG_N     = 7'b0101011;
  localparam seg_t SEG_R     = 7'b0101111;

endpackage

// File: rtl/bc_seg_decode.sv
// -----------------------------------------------------------------------------
// bc_seg_decode
// Purely combinational character-code to 7-segment decoder.
//
// Ports:
//   code  in   5-bit character code (0-15 hex, 16 blank, 17 dash, 18-22 letters)
//   seg   out  active-low segments {g,f,e,d,c,b,a}; any unused code is blank
// -----------------------------------------------------------------------------
module bc_seg_decode
  import bc_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  seg
);

  // Hex digits use the usual Nexys glyphs, with b and d drawn lowercase so
  // they cannot be mistaken for 8 and 0. Everything not listed falls to blank.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:    seg = 7'b1000000;
      5'd1:    seg = 7'b1111001;
      5'd2:    seg = 7'b0100100;
      5'd3:    seg = 7'b0110000;
      5'd4:    seg = 7'b0011001;
      5'd5:    seg = 7'b0010010;
      5'd6:    seg = 7'b0000010;
      5'd7:    seg = 7'b1111000;
      5'd8:    seg = 7'b0000000;
      5'd9:    seg = 7'b0010000;
      5'd10:   seg = 7'b0001000;
      5'd11:   seg = 7'b0000011;
      5'd12:   seg = 7'b1000110;
      5'd13:   seg = 7'b0100001;
      5'd14:   seg = 7'b0000110;
      5'd15:   seg = 7'b0001110;
      CH_DASH: seg = SEG_DASH;
      CH_P:    seg = SEG_P;
      CH_L:    seg = SEG_L;
      CH_U:    seg = SEG_U;
      CH_N:    seg = SEG_N;
      CH_R:    seg = SEG_R;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bc_display_scan.sv
// -----------------------------------------------------------------------------
// bc_display_scan
// Time-multiplexed driver for the eight 7-segment displays. A frame arrives
// through a valid/ready handshake into a pending buffer, and is copied into the
// active buffer only at a frame boundary so a frame is never shown half-old,
// half-new. The active buffer is scanned one digit per slot onto the pins.
//
// Ports:
//   clock        in   single system clock
//   reset        in   synchronous, active-high
//   frame_chars  in   5 bits per display; [5i+4:5i] is display i (0 = rightmost)
//   frame_blink  in   bit i set makes display i blink
//   frame_valid  in   frame_chars/frame_blink are valid
//   frame_ready  out  pending buffer is empty; accepted when valid && ready
//   frame_done   out  high for the single cycle of each frame boundary
//   an           out  anode enables, active-low
//   digit        out  segments {g,f,e,d,c,b,a}, active-low, no decimal point
// -----------------------------------------------------------------------------
module bc_display_scan
  import bc_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [5*NUM_DIGITS-1:0]  frame_chars,
  input  logic [NUM_DIGITS-1:0]    frame_blink,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output logic                     frame_done,
  output logic [NUM_DIGITS-1:0]    an,
  output logic [SEG_W-1:0]         digit
);

  localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W  = $clog2(BLINK_FRAMES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  localparam logic [5*NUM_DIGITS-1:0] BLANK_FRAME = {NUM_DIGITS{CH_BLANK}};

  logic [TICK_W-1:0]        tick_q, tick_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic [BLK_W-1:0]         blink_cnt_q, blink_cnt_d;
  logic                     blink_phase_q, blink_phase_d;
  logic                     pend_full_q, pend_full_d;
  logic [5*NUM_DIGITS-1:0]  pend_chars_q, pend_chars_d;
  logic [NUM_DIGITS-1:0]    pend_blink_q, pend_blink_d;
  logic [5*NUM_DIGITS-1:0]  act_chars_q, act_chars_d;
  logic [NUM_DIGITS-1:0]    act_blink_q, act_blink_d;
  logic [NUM_DIGITS-1:0]    an_q, an_d;
  logic [SEG_W-1:0]         digit_q, digit_d;

  logic                     slot_tick;
  logic                     boundary;
  logic                     accept;
  logic [CODE_W-1:0]        cur_code;
  logic [SEG_W-1:0]         cur_seg;

  // Timing skeleton: the tick counter paces the digit slots, and the last slot
  // tick of the last digit is the frame boundary where buffers swap.
  always_comb begin
    slot_tick = (tick_q == TICK_LAST);
    boundary  = slot_tick && (index_q == IDX_LAST);
    accept    = frame_valid && !pend_full_q;

    tick_d = slot_tick ? '0 : tick_q + 1'b1;

    index_d = index_q;
    if (slot_tick) begin
      index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
    end
  end

  // Double buffer. Ready is derived from the pending flag, so an accept and a
  // swap can never both happen in one cycle: a swap needs pending full, an
  // accept needs it empty. A frame accepted on a boundary cycle therefore waits
  // for the following boundary.
  always_comb begin
    pend_full_d  = pend_full_q;
    pend_chars_d = pend_chars_q;
    pend_blink_d = pend_blink_q;
    act_chars_d  = act_chars_q;
    act_blink_d  = act_blink_q;

    if (boundary && pend_full_q) begin
      act_chars_d = pend_chars_q;
      act_blink_d = pend_blink_q;
      pend_full_d = 1'b0;
    end

    if (accept) begin
      pend_chars_d = frame_chars;
      pend_blink_d = frame_blink;
      pend_full_d  = 1'b1;
    end
  end

  // Blink timebase counts whole frames, so the blink edges line up with frame
  // boundaries and a blinking digit never flickers mid-frame.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (boundary) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Pin drive. Anode and segments are both derived from the current index and
  // registered together, so they change on the same edge. A blinking digit in
  // its off phase keeps its segment pattern; only its anode is held off.
  always_comb begin
    cur_code = CH_BLANK;
    an_d     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == index_q) begin
        cur_code = act_chars_q[5*i +: 5];
        an_d[i]  = act_blink_q[i] && blink_phase_q;
      end
    end
    digit_d = cur_seg;
  end

  bc_seg_decode u_seg_decode (
    .code (cur_code),
    .seg  (cur_seg)
  );

  // All state, including both buffers, is cleared on reset so that any frame
  // in flight is dropped and the display restarts blank.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_q        <= '0;
      index_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pend_full_q   <= 1'b0;
      pend_chars_q  <= BLANK_FRAME;
      pend_blink_q  <= '0;
      act_chars_q   <= BLANK_FRAME;
      act_blink_q   <= '0;
      an_q          <= '1;
      digit_q       <= SEG_BLANK;
    end else begin
      tick_q        <= tick_d;
      index_q       <= index_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_full_q   <= pend_full_d;
      pend_chars_q  <= pend_chars_d;
      pend_blink_q  <= pend_blink_d;
      act_chars_q   <= act_chars_d;
      act_blink_q   <= act_blink_d;
      an_q          <= an_d;
      digit_q       <= digit_d;
    end
  end

  assign frame_ready = !pend_full_q;
  assign frame_done  = boundary;
  assign an          = an_q;
  assign digit       = digit_q;

endmodule

// File: tb/tb_bc_display_scan.sv
// -----------------------------------------------------------------------------
// tb_bc_display_scan
// Drives frames into bc_display_scan (REFRESH_DIV=4, BLINK_FRAMES=2) and checks
// every cycle of the pin output against a reference model built from cycle
// arithmetic: slot = (cycle-1)/REFRESH_DIV mod NUM_DIGITS, boundaries every
// NUM_DIGITS*REFRESH_DIV cycles, blink phase = (frames/BLINK_FRAMES) mod 2.
// Accepted frames go into a scoreboard queue and the monitor retires them into
// the model's active frame at the boundary where they should take effect.
// -----------------------------------------------------------------------------
module tb_bc_display_scan;

  localparam int ND        = 8;
  localparam int RD        = 4;
  localparam int BF        = 2;
  localparam int FRAME_CYC = ND * RD;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [5*ND-1:0] frame_chars = '0;
  logic [ND-1:0]   frame_blink = '0;
  logic            frame_valid = 1'b0;
  logic            frame_ready;
  logic            frame_done;
  logic [ND-1:0]   an;
  logic [6:0]      digit;

  bc_display_scan #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_chars (frame_chars),
    .frame_blink (frame_blink),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_done  (frame_done),
    .an          (an),
    .digit       (digit)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5*ND-1:0] chars;
    logic [ND-1:0]   blink;
    int              acc;
  } frame_t;

  frame_t     sb_q[$];
  frame_t     m_pop;
  logic [4:0] m_chars [ND];
  logic [ND-1:0] m_blink;
  logic [ND-1:0] m_an;
  int         m_slot;
  int         m_phase;
  int         k = -1;
  bit         rst_prev = 1'b0;
  int         checks = 0;
  int         errors = 0;

  // Reference glyphs, active-low {g,f,e,d,c,b,a}.
  logic [6:0] glyph [32] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
    7'h7F, 7'h3F, 7'h0C, 7'h47, 7'h41, 7'h2B, 7'h2F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  // One comparison: counts it, and reports it only when it differs.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, k);
    end
  endtask

  // Monitor and scoreboard. Cycle k is the interval after the k-th edge
  // following the reset edge. Pins in cycle k reflect the slot and frame that
  // were current in cycle k-1, so the model compares before advancing.
  always @(negedge clock) begin
    if (rst_prev) begin
      k = 0;
      sb_q.delete();
      for (int i = 0; i < ND; i++) m_chars[i] = 5'd16;
      m_blink = '0;
      checkOutput("reset_an", an, 8'hFF);
      checkOutput("reset_digit", digit, 7'h7F);
      checkOutput("reset_ready", frame_ready, 1);
      checkOutput("reset_done", frame_done, 0);
    end else if (k >= 0) begin
      k++;
      m_slot  = ((k - 1) / RD) % ND;
      m_phase = (((k - 1) / FRAME_CYC) / BF) % 2;
      m_an = '1;
      if (!(m_blink[m_slot] && m_phase == 1)) m_an[m_slot] = 1'b0;
      checkOutput("an", an, m_an);
      checkOutput("digit", digit, glyph[m_chars[m_slot]]);
      if ((k % FRAME_CYC) == 0 && sb_q.size() > 0 && sb_q[0].acc < k - 1) begin
        m_pop = sb_q.pop_front();
        for (int i = 0; i < ND; i++) m_chars[i] = m_pop.chars[5*i +: 5];
        m_blink = m_pop.blink;
      end
      checkOutput("ready", frame_ready, (sb_q.size() == 0) ? 1 : 0);
      checkOutput("done", frame_done, ((k % FRAME_CYC) == FRAME_CYC - 1) ? 1 : 0);
    end
    if (k >= 0 && !reset && frame_valid && sb_q.size() == 0) begin
      sb_q.push_back('{chars: frame_chars, blink: frame_blink, acc: k});
    end
    rst_prev = reset;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Waits until the cycle count sits at a given offset within a frame.
  task automatic waitFrameOffset(input int target);
    int guard;
    guard = 0;
    while ((k % FRAME_CYC) != target && guard < 4 * FRAME_CYC) begin
      @(posedge clock);
      #1;
      guard++;
    end
    checks++;
    if ((k % FRAME_CYC) != target) begin
      errors++;
      $display("[TB] FAIL frame_offset: got %0d expected %0d", k % FRAME_CYC, target);
    end
  endtask

  // Offers one frame and holds it stable until the handshake completes.
  task automatic applyStimulus(input logic [5*ND-1:0] chars, input logic [ND-1:0] blink);
    int wait_cnt;
    @(posedge clock);
    #1;
    frame_chars = chars;
    frame_blink = blink;
    frame_valid = 1'b1;
    wait_cnt = 0;
    do begin
      @(negedge clock);
      wait_cnt++;
    end while (!frame_ready && wait_cnt < 4 * FRAME_CYC);
    checks++;
    if (!frame_ready) begin
      errors++;
      $display("[TB] FAIL handshake_timeout: ready %0b expected 1 within %0d cycles", frame_ready, 4 * FRAME_CYC);
    end
    @(posedge clock);
    #1;
    frame_valid = 1'b0;
    frame_chars = {$urandom, $urandom};
    frame_blink = ND'($urandom);
  endtask

  task automatic applyReset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [5*ND-1:0] randomChars();
    logic [5*ND-1:0] c;
    for (int i = 0; i < ND; i++) c[5*i +: 5] = 5'($urandom_range(0, 31));
    return c;
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5*ND-1:0] c;

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    $display("[TB] idle blank scan");
    waitCycles(2 * FRAME_CYC + 8);

    $display("[TB] single frame, char0=1, rest 0");
    applyStimulus(40'd1, 8'h00);
    waitCycles(2 * FRAME_CYC);

    $display("[TB] back-to-back frames");
    applyStimulus(randomChars(), 8'h00);
    applyStimulus(randomChars(), 8'h00);
    waitCycles(2 * FRAME_CYC);

    $display("[TB] blink digit 0 over all dashes");
    applyStimulus({ND{5'd17}}, 8'h01);
    waitCycles(6 * FRAME_CYC);

    $display("[TB] unused code and blank in slot 3");
    c = randomChars();
    c[15 +: 5] = 5'd25;
    applyStimulus(c, 8'h00);
    c = randomChars();
    c[15 +: 5] = 5'd16;
    applyStimulus(c, 8'h00);
    waitCycles(2 * FRAME_CYC);

    $display("[TB] reset mid-frame with pending full");
    waitFrameOffset(0);
    applyStimulus(randomChars(), 8'hA5);
    waitFrameOffset(21);
    applyReset();
    waitCycles(FRAME_CYC + 4);

    $display("[TB] randomized frames");
    for (int n = 0; n < 24; n++) begin
      c = randomChars();
      applyStimulus(c, ($urandom_range(0, 2) == 0) ? ND'($urandom) : '0);
      waitCycles($urandom_range(0, 40));
    end
    waitCycles(3 * FRAME_CYC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
